xm23_kbscr_dev: RTL and testbench
=================================

// Module: xm23_kbscr_dev
// PURPOSE
// Memory-mapped keyboard/screen device responder on the XM23 CPU load/store bus. CPU is initiator (MAR/MDR,
// byte/word, RD/WR). Block owns the four device bytes (KB_CSR, KB_DATA, SCR_CSR, SCR_DATA) and their DBA/OF/IE side effects.
// It bridges to the external terminal link: accepts keyboard bytes in and streams screen bytes out with handshakes.
// Raises level interrupts to the PIC.
// PARAMETERS
// DEV_BASE    16'h0000  byte address of KB_CSR; window is DEV_BASE..DEV_BASE+3
// TX_GAP      4         idle cycles after each screen byte before SCR DBA re-asserts (0 = none)
// PORTS
// Clock       in   1   system clock, all state on posedge
// Reset       in   1   asynchronous, active-high
// bus_addr    in   16  byte address (from MAR)
// bus_wdata   in   16  write data (from MDR); byte writes use [7:0]
// bus_rd      in   1   read strobe, one cycle per access
// bus_wr      in   1   write strobe, one cycle per access
// bus_byte    in   1   1 = byte access, 0 = word (little-endian: [7:0]@addr, [15:8]@addr+1)
// bus_hit     out  1   combinational: bus_addr inside window
// bus_rdata   out  16  registered read data
// bus_ack     out  1   one-cycle pulse, cycle after any in-window rd/wr
// kb_byte     in   8   keyboard byte from link
// kb_valid    in   1   kb_byte valid
// kb_ready    out  1   = KB_CSR.ENA
// scr_byte    out  8   screen byte to link
// scr_valid   out  1   scr_byte valid
// scr_ready   in   1   link accepts scr_byte
// kb_irq      out  1   KB_CSR.IE & KB_CSR.DBA
// scr_irq     out  1   SCR_CSR.IE & SCR_CSR.DBA
// BEHAVIOUR
// CSR bits: [0] IE rw, [1] IO ro (KB=0 input, SCR=1 output), [2] DBA, [3] OF, [4] ENA rw, [7:5] read 0.
// Reset: KB_CSR=8'h10, SCR_CSR=8'h16, KB_DATA=SCR_DATA=0, bus_rdata=0, bus_ack=0, scr_valid=0, scr_byte=0, FSM=IDLE.
// Reads: side effects applied in strobe cycle; bus_rdata/bus_ack valid next cycle. Out-of-window strobes ignored, no ack.
// Word access: addr bit0 ignored (aligned down). Bytes read/written = offsets covered by access.
// rd and wr same cycle: wr wins, rd ignored.
// KB receive: kb_valid & kb_ready -> KB_DATA<=kb_byte; OF<=1 if DBA already 1; DBA<=1.
// KB_DATA read clears DBA. Same-cycle read and new byte: read returns old byte; DBA stays 1; KB_DATA updated; OF unchanged.
// CSR write (either device): IE, ENA <= wdata; DBA, OF cleared by writing 0, writing 1 ignored; IO ignored.
// KB_DATA writes ignored.
// Screen FSM (states IDLE, SEND, GAP):
//   IDLE: SCR_DATA write with DBA=1 and ENA=1 -> latch byte, DBA<=0, scr_byte<=byte, scr_valid<=1, go SEND.
//   SCR_DATA write with DBA=0 -> OF<=1, byte dropped, no state change. Write with ENA=0 -> latched, not sent, DBA unchanged.
//   SEND: hold scr_valid/scr_byte until scr_ready; on scr_ready -> scr_valid<=0, load gap counter TX_GAP; GAP (IDLE if TX_GAP=0).
//   GAP: counter decrements to 0, then DBA<=1, -> IDLE.
//   ENA cleared mid-transfer: current byte completes; ENA only gates new starts.
// Gap counter width $clog2(TX_GAP+1), min 1; no wrap (stops at 0).
// Reset mid-SEND: scr_valid drops asynchronously; byte lost; DBA=1.
// STRUCTURE
// Package xm23_dev_pkg: offsets KB_CSR=0..SCR_DATA=3; CSR bit indices IE/IO/DBA/OF/ENA; reset values 8'h10/8'h16.
// Package xm23_dev_pkg also holds the FSM state encoding.
// Sub-module xm23_scr_tx: SEND/GAP FSM + gap counter, start/byte in, done pulse out. Parent owns CSRs and bus decode.
// TESTING
// Reset -> word rd @0 gives 16'h0010, word rd @2 gives 16'h0016; kb_ready=1; scr_valid=0; irqs 0.
// kb byte 8'h41 -> KB DBA=1. Byte rd @1 returns 8'h41 after 1 cycle, ack pulse; DBA=0 on next CSR read.
// Two kb bytes 8'h41, 8'h42 with no read -> KB_CSR=8'h1C; KB_DATA=8'h42. Write 8'h11 to @0 -> 8'h11 (OF, DBA cleared, IE set), kb_irq=0.
// Byte wr 8'h6B @3 -> scr_valid=1, scr_byte=8'h6B. Hold scr_ready=0 for 5 cycles: outputs stable.
// Same case, then scr_ready=1 -> DBA returns exactly TX_GAP+1 cycles later. scr_irq follows DBA if IE=1.
// Second wr @3 while DBA=0 -> SCR OF=1; in-flight byte unchanged.
// Assert Reset mid-SEND -> scr_valid=0 immediately; CSRs at reset values.
// Word rd @1 (aligned to 0) with simultaneous kb_valid -> returns old pair; KB DBA=1 after.
// Strobe @ DEV_BASE+4 -> bus_hit=0, no ack, no state change.

Source files
------------

// File: rtl/xm23_dev_pkg.sv
// Shared definitions for the XM23 keyboard/screen device: register offsets,
// CSR bit positions, CSR reset images and the screen transmitter state encoding.
package xm23_dev_pkg;

  // Byte offsets of the four device registers inside the bus window
  localparam logic [1:0] OFF_KB_CSR   = 2'd0;
  localparam logic [1:0] OFF_KB_DATA  = 2'd1;
  localparam logic [1:0] OFF_SCR_CSR  = 2'd2;
  localparam logic [1:0] OFF_SCR_DATA = 2'd3;

  // CSR bit positions (bits [7:5] always read as zero)
  localparam int CSR_IE  = 0;
  localparam int CSR_IO  = 1;
  localparam int CSR_DBA = 2;
  localparam int CSR_OF  = 3;
  localparam int CSR_ENA = 4;

  // CSR images after reset: keyboard enabled and empty, screen enabled and ready
  localparam logic [7:0] KB_CSR_RST  = 8'h10;
  localparam logic [7:0] SCR_CSR_RST = 8'h16;

  // Screen transmitter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } scr_state_e;

  // Assemble a CSR byte from its individual flags
  function automatic logic [7:0] pack_csr(input logic ie, input logic io,
                                          input logic dba, input logic of_bit,
                                          input logic ena);
    logic [7:0] csr;
    csr          = 8'h00;
    csr[CSR_IE]  = ie;
    csr[CSR_IO]  = io;
    csr[CSR_DBA] = dba;
    csr[CSR_OF]  = of_bit;
    csr[CSR_ENA] = ena;
    return csr;
  endfunction

endpackage

// File: rtl/xm23_scr_tx.sv
// Screen byte transmitter: presents one byte to the terminal link with a
// valid/ready handshake, then waits TX_GAP idle cycles and pulses done.
module xm23_scr_tx
  import xm23_dev_pkg::*;
#(
  parameter int TX_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       ready_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       done_o,
  output logic       busy_o
);

  localparam int CNT_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(TX_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic             valid_q;
  logic             done_q;

  // Handshake FSM; done fires on the cycle the gap counter reaches zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            byte_q  <= byte_i;
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (TX_GAP == 0) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= GAP_LOAD;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q <= CNT_ONE) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/xm23_kbscr_dev.sv
// XM23 keyboard/screen device: decodes the CPU load/store bus window, owns the
// keyboard and screen CSR/DATA bytes, and bridges to the terminal link.
module xm23_kbscr_dev
  import xm23_dev_pkg::*;
#(
  parameter logic [15:0] DEV_BASE = 16'h0000,
  parameter int          TX_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic        bus_byte,
  output logic        bus_hit,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  input  logic [7:0]  kb_byte,
  input  logic        kb_valid,
  output logic        kb_ready,
  output logic [7:0]  scr_byte,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        kb_irq,
  output logic        scr_irq
);

  // Keyboard registers
  logic       kb_ie_q,  kb_ie_d;
  logic       kb_dba_q, kb_dba_d;
  logic       kb_of_q,  kb_of_d;
  logic       kb_ena_q, kb_ena_d;
  logic [7:0] kb_data_q, kb_data_d;

  // Screen registers
  logic       scr_ie_q,  scr_ie_d;
  logic       scr_dba_q, scr_dba_d;
  logic       scr_of_q,  scr_of_d;
  logic       scr_ena_q, scr_ena_d;
  logic [7:0] scr_data_q, scr_data_d;

  // Bus response registers
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q;

  // Decode signals
  logic [15:0] off;
  logic [3:0]  sel;
  logic        rd_go, wr_go;
  logic [7:0]  wb_csr, wb_data;
  logic [7:0]  rd_bytes [4];

  // Transmitter interface
  logic       tx_start, tx_done, tx_busy;
  logic       kb_rx;
  logic       kb_csr_wr, kb_data_rd;
  logic       scr_csr_wr, scr_data_wr;

  // Window decode and byte-lane selection; word accesses align down to even
  always_comb begin
    off     = bus_addr - DEV_BASE;
    bus_hit = (off < 16'd4);
    wr_go   = bus_wr & bus_hit;
    rd_go   = bus_rd & bus_hit & ~bus_wr;
    sel     = 4'b0000;
    if (bus_byte) begin
      sel[off[1:0]] = 1'b1;
    end else if (off[1]) begin
      sel = 4'b1100;
    end else begin
      sel = 4'b0011;
    end
    // Even offsets always take the low lane; odd offsets take the high lane on word writes
    wb_csr  = bus_wdata[7:0];
    wb_data = bus_byte ? bus_wdata[7:0] : bus_wdata[15:8];
  end

  assign kb_rx       = kb_valid & kb_ena_q;
  assign kb_csr_wr   = wr_go & sel[OFF_KB_CSR];
  assign kb_data_rd  = rd_go & sel[OFF_KB_DATA];
  assign scr_csr_wr  = wr_go & sel[OFF_SCR_CSR];
  assign scr_data_wr = wr_go & sel[OFF_SCR_DATA];
  assign tx_start    = scr_data_wr & scr_dba_q & scr_ena_q & ~tx_busy;

  // Read mux over the current (pre-side-effect) register images
  always_comb begin
    rd_bytes[0] = pack_csr(kb_ie_q, 1'b0, kb_dba_q, kb_of_q, kb_ena_q);
    rd_bytes[1] = kb_data_q;
    rd_bytes[2] = pack_csr(scr_ie_q, 1'b1, scr_dba_q, scr_of_q, scr_ena_q);
    rd_bytes[3] = scr_data_q;
    rdata_d     = rdata_q;
    if (rd_go) begin
      if (bus_byte) begin
        rdata_d = {8'h00, rd_bytes[off[1:0]]};
      end else begin
        rdata_d = {rd_bytes[{off[1], 1'b1}], rd_bytes[{off[1], 1'b0}]};
      end
    end
  end

  // Keyboard CSR/DATA next state: CSR writes, link receive, DATA-read consume
  always_comb begin
    kb_ie_d   = kb_ie_q;
    kb_dba_d  = kb_dba_q;
    kb_of_d   = kb_of_q;
    kb_ena_d  = kb_ena_q;
    kb_data_d = kb_data_q;
    if (kb_csr_wr) begin
      kb_ie_d  = wb_csr[CSR_IE];
      kb_ena_d = wb_csr[CSR_ENA];
      if (!wb_csr[CSR_DBA]) kb_dba_d = 1'b0;
      if (!wb_csr[CSR_OF])  kb_of_d  = 1'b0;
    end
    if (kb_rx) begin
      // A simultaneous DATA read consumes the old byte, so no overflow then
      kb_data_d = kb_byte;
      if (kb_dba_q && !kb_data_rd) kb_of_d = 1'b1;
      kb_dba_d = 1'b1;
    end else if (kb_data_rd) begin
      kb_dba_d = 1'b0;
    end
  end

  // Screen CSR/DATA next state: CSR writes, DATA write start/overflow, transmit done
  always_comb begin
    scr_ie_d   = scr_ie_q;
    scr_dba_d  = scr_dba_q;
    scr_of_d   = scr_of_q;
    scr_ena_d  = scr_ena_q;
    scr_data_d = scr_data_q;
    if (scr_csr_wr) begin
      scr_ie_d  = wb_csr[CSR_IE];
      scr_ena_d = wb_csr[CSR_ENA];
      if (!wb_csr[CSR_DBA]) scr_dba_d = 1'b0;
      if (!wb_csr[CSR_OF])  scr_of_d  = 1'b0;
    end
    if (scr_data_wr) begin
      if (!scr_dba_q) begin
        scr_of_d = 1'b1;
      end else begin
        // With ENA clear the byte is only latched; DBA stays set
        scr_data_d = wb_data;
        if (tx_start) scr_dba_d = 1'b0;
      end
    end
    if (tx_done) scr_dba_d = 1'b1;
  end

  // Device register state and bus response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_ie_q    <= KB_CSR_RST[CSR_IE];
      kb_dba_q   <= KB_CSR_RST[CSR_DBA];
      kb_of_q    <= KB_CSR_RST[CSR_OF];
      kb_ena_q   <= KB_CSR_RST[CSR_ENA];
      kb_data_q  <= 8'h00;
      scr_ie_q   <= SCR_CSR_RST[CSR_IE];
      scr_dba_q  <= SCR_CSR_RST[CSR_DBA];
      scr_of_q   <= SCR_CSR_RST[CSR_OF];
      scr_ena_q  <= SCR_CSR_RST[CSR_ENA];
      scr_data_q <= 8'h00;
      rdata_q    <= 16'h0000;
      ack_q      <= 1'b0;
    end else begin
      kb_ie_q    <= kb_ie_d;
      kb_dba_q   <= kb_dba_d;
      kb_of_q    <= kb_of_d;
      kb_ena_q   <= kb_ena_d;
      kb_data_q  <= kb_data_d;
      scr_ie_q   <= scr_ie_d;
      scr_dba_q  <= scr_dba_d;
      scr_of_q   <= scr_of_d;
      scr_ena_q  <= scr_ena_d;
      scr_data_q <= scr_data_d;
      rdata_q    <= rdata_d;
      ack_q      <= rd_go | wr_go;
    end
  end

  xm23_scr_tx #(
    .TX_GAP (TX_GAP)
  ) u_scr_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (tx_start),
    .byte_i  (wb_data),
    .ready_i (scr_ready),
    .byte_o  (scr_byte),
    .valid_o (scr_valid),
    .done_o  (tx_done),
    .busy_o  (tx_busy)
  );

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign kb_ready  = kb_ena_q;
  assign kb_irq    = kb_ie_q & kb_dba_q;
  assign scr_irq   = scr_ie_q & scr_dba_q;

endmodule

// File: tb/tb_xm23_kbscr_dev.sv
// Directed bench for the XM23 keyboard/screen device (DEV_BASE=0, TX_GAP=4).
module tb_xm23_kbscr_dev;

  localparam int TX_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_byte = 1'b0;
  logic        bus_hit;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  kb_byte = '0;
  logic        kb_valid = 1'b0;
  logic        kb_ready;
  logic [7:0]  scr_byte;
  logic        scr_valid;
  logic        scr_ready = 1'b0;
  logic        kb_irq;
  logic        scr_irq;

  int checks = 0;
  int failures = 0;

  xm23_kbscr_dev #(
    .DEV_BASE (16'h0000),
    .TX_GAP   (TX_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_byte  (bus_byte),
    .bus_hit   (bus_hit),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .kb_byte   (kb_byte),
    .kb_valid  (kb_valid),
    .kb_ready  (kb_ready),
    .scr_byte  (scr_byte),
    .scr_valid (scr_valid),
    .scr_ready (scr_ready),
    .kb_irq    (kb_irq),
    .scr_irq   (scr_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one strobe cycle and returns at the next negedge
  task automatic access(input logic rd, input logic wr, input logic bt,
                        input logic [15:0] a, input logic [15:0] wd);
    bus_rd = rd; bus_wr = wr; bus_byte = bt; bus_addr = a; bus_wdata = wd;
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic kb_push(input logic [7:0] b);
    kb_byte = b; kb_valid = 1'b1;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ack",   {15'd0, bus_ack},   16'h0000);
    chk("rst_rdata", bus_rdata,          16'h0000);
    chk("rst_sv",    {15'd0, scr_valid}, 16'h0000);
    chk("rst_sbyte", {8'd0, scr_byte},   16'h0000);
    chk("rst_kbrdy", {15'd0, kb_ready},  16'h0001);
    chk("rst_irqs",  {14'd0, kb_irq, scr_irq}, 16'h0000);
    access(1, 0, 0, 16'h0000, 16'h0);
    chk("rst_rd0",   bus_rdata, 16'h0010);
    chk("rst_ack1",  {15'd0, bus_ack}, 16'h0001);
    access(1, 0, 0, 16'h0002, 16'h0);
    chk("rst_rd2",   bus_rdata, 16'h0016);
    @(negedge clk);
    chk("ack_pulse", {15'd0, bus_ack}, 16'h0000);

    // Single keyboard byte, consumed by a DATA read
    kb_push(8'h41);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("kb_csr_dba", bus_rdata, 16'h0014);
    access(1, 0, 1, 16'h0001, 16'h0);
    chk("kb_data41", bus_rdata, 16'h0041);
    chk("kb_rd_ack", {15'd0, bus_ack}, 16'h0001);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("kb_dba_clr", bus_rdata, 16'h0010);

    // Overflow, then CSR write clears DBA/OF and sets IE
    kb_push(8'h41);
    kb_push(8'h42);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("kb_of_csr", bus_rdata, 16'h001C);
    access(1, 0, 0, 16'h0000, 16'h0);
    chk("kb_word", bus_rdata, 16'h421C);
    access(0, 1, 1, 16'h0000, 16'h0011);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("kb_csr_w11", bus_rdata, 16'h0011);
    chk("kb_irq_off", {15'd0, kb_irq}, 16'h0000);
    kb_push(8'h55);
    chk("kb_irq_on", {15'd0, kb_irq}, 16'h0001);
    access(1, 0, 1, 16'h0001, 16'h0);
    chk("kb_data55", bus_rdata, 16'h0055);
    chk("kb_irq_clr", {15'd0, kb_irq}, 16'h0000);
    access(0, 1, 1, 16'h0001, 16'h0077);
    access(1, 0, 1, 16'h0001, 16'h0);
    chk("kb_data_ro", bus_rdata, 16'h0055);
    // rd and wr together: write applied, read ignored (rdata holds)
    access(1, 1, 1, 16'h0000, 16'h0010);
    chk("rdwr_ack",  {15'd0, bus_ack}, 16'h0001);
    chk("rdwr_hold", bus_rdata, 16'h0055);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("rdwr_csr", bus_rdata, 16'h0010);

    // Screen: enable IE keeping DBA, start a byte, hold off ready
    access(0, 1, 1, 16'h0002, 16'h0015);
    access(1, 0, 1, 16'h0002, 16'h0);
    chk("scr_csr17", bus_rdata, 16'h0017);
    chk("scr_irq_rdy", {15'd0, scr_irq}, 16'h0001);
    access(0, 1, 1, 16'h0003, 16'h006B);
    chk("scr_sv",    {15'd0, scr_valid}, 16'h0001);
    chk("scr_byte",  {8'd0, scr_byte},   16'h006B);
    chk("scr_irq_busy", {15'd0, scr_irq}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("scr_hold_v", {15'd0, scr_valid}, 16'h0001);
      chk("scr_hold_b", {8'd0, scr_byte},   16'h006B);
    end
    access(0, 1, 1, 16'h0003, 16'h0099);
    access(1, 0, 1, 16'h0002, 16'h0);
    chk("scr_of", bus_rdata, 16'h001B);
    access(1, 0, 1, 16'h0003, 16'h0);
    chk("scr_data_kept", bus_rdata, 16'h006B);
    chk("scr_inflight", {8'd0, scr_byte}, 16'h006B);

    // Accept, then DBA/irq returns exactly TX_GAP+1 cycles later
    scr_ready = 1'b1;
    @(negedge clk);
    scr_ready = 1'b0;
    chk("scr_accept_v", {15'd0, scr_valid}, 16'h0000);
    chk("scr_gap_irq0", {15'd0, scr_irq}, 16'h0000);
    for (int k = 1; k <= TX_GAP + 1; k++) begin
      @(negedge clk);
      chk("scr_gap_irq", {15'd0, scr_irq}, (k >= TX_GAP + 1) ? 16'h0001 : 16'h0000);
    end
    access(1, 0, 1, 16'h0002, 16'h0);
    chk("scr_csr_done", bus_rdata, 16'h001F);

    // Reset in the middle of a send
    access(0, 1, 1, 16'h0003, 16'h0033);
    chk("scr_sv33", {15'd0, scr_valid}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_v", {15'd0, scr_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 0, 16'h0000, 16'h0);
    chk("rst2_rd0", bus_rdata, 16'h0010);
    access(1, 0, 0, 16'h0002, 16'h0);
    chk("rst2_rd2", bus_rdata, 16'h0016);

    // Word read at odd address together with an incoming keyboard byte
    kb_push(8'h41);
    bus_rd = 1'b1; bus_wr = 1'b0; bus_byte = 1'b0; bus_addr = 16'h0001;
    kb_byte = 8'h42; kb_valid = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0; kb_valid = 1'b0;
    chk("coll_rdata", bus_rdata, 16'h4114);
    access(1, 0, 1, 16'h0000, 16'h0);
    chk("coll_csr", bus_rdata, 16'h0014);
    access(1, 0, 1, 16'h0001, 16'h0);
    chk("coll_data", bus_rdata, 16'h0042);

    // Out-of-window strobes
    bus_addr = 16'h0003;
    #1;
    chk("hit_in", {15'd0, bus_hit}, 16'h0001);
    @(negedge clk);
    bus_wr = 1'b1; bus_byte = 1'b1; bus_addr = 16'h0004; bus_wdata = 16'h0000;
    #1;
    chk("hit_out", {15'd0, bus_hit}, 16'h0000);
    @(negedge clk);
    bus_wr = 1'b0;
    chk("oow_wr_ack", {15'd0, bus_ack}, 16'h0000);
    access(1, 0, 0, 16'h0004, 16'h0);
    chk("oow_rd_ack", {15'd0, bus_ack}, 16'h0000);
    chk("oow_rdata",  bus_rdata, 16'h0042);
    access(1, 0, 0, 16'h0000, 16'h0);
    chk("oow_nochg", bus_rdata, 16'h4210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
